// File: rtl/lampFPU_pkg.sv
// Shared widths, extended-fraction field indices and rounding helpers for the
// bf16 LAMP FPU datapath.
package lampFPU_pkg;

  localparam int LAMP_FLOAT_E_DW   = 8;
  localparam int LAMP_FLOAT_F_DW   = 7;
  localparam int LAMP_FLOAT_DW     = 16;
  localparam int LAMP_FLOAT_E_BIAS = 127;
  localparam int LAMP_FLOAT_EXT_DW = 12;

  // Extended fraction layout: carry | hidden | fraction[6:0] | G | R | S
  localparam int LAMP_EXT_CARRY_IDX  = 11;
  localparam int LAMP_EXT_HIDDEN_IDX = 10;
  localparam int LAMP_EXT_F_MSB_IDX  = 9;
  localparam int LAMP_EXT_F_LSB_IDX  = 3;
  localparam int LAMP_EXT_G_IDX      = 2;
  localparam int LAMP_EXT_R_IDX      = 1;
  localparam int LAMP_EXT_S_IDX      = 0;

  localparam logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW-1:0] INF_E_F  = {8'hFF, 7'h00};
  localparam logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW-1:0] ZERO_E_F = '0;

  // Stage-1 payload: rounded (not yet renormalised) significand and 9-bit exponent.
  typedef struct packed {
    logic                       s;
    logic [LAMP_FLOAT_E_DW:0]   e;
    logic [LAMP_FLOAT_F_DW+1:0] sig;
    logic                       inx;
    logic                       to_round;
    logic                       ovf;
    logic                       unf;
  } rp_s1_t;

  typedef struct packed {
    logic [LAMP_FLOAT_DW-1:0] res;
    logic                     ovf;
    logic                     unf;
    logic                     inx;
  } rp_s2_t;

  function automatic logic FUNC_rne_increment(input logic l, input logic g,
                                              input logic r, input logic s);
    return g & (r | s | l);
  endfunction

endpackage

// File: rtl/lamp_fpu_pipe_reg.sv
// Single valid/ready register slice; accepts whenever empty or draining.
module lamp_fpu_pipe_reg #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [DW-1:0] data_o
);

  logic          valid_d, valid_q;
  logic [DW-1:0] data_d, data_q;

  assign ready_o = ~valid_q | ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ready_o) begin
      valid_d = valid_i;
      if (valid_i) data_d = data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/lamp_fpu_round_pack.sv
// Two-stage round-to-nearest-even and pack of bf16 results, with per-result
// and sticky exception flags.
module lamp_fpu_round_pack
  import lampFPU_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic                         s_i,
  input  logic [LAMP_FLOAT_E_DW-1:0]   e_i,
  input  logic [LAMP_FLOAT_EXT_DW-1:0] f_i,
  input  logic                         isToRound_i,
  input  logic                         isOverflow_i,
  input  logic                         isUnderflow_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [LAMP_FLOAT_DW-1:0]     res_o,
  output logic                         ovf_o,
  output logic                         unf_o,
  output logic                         inx_o,
  output logic [2:0]                   flags_o,
  input  logic                         clear_flags_i
);

  localparam int S1_W = $bits(rp_s1_t);
  localparam int S2_W = $bits(rp_s2_t);

  rp_s1_t            s1_d, s1_q;
  rp_s2_t            s2_d, s2_q;
  logic [S1_W-1:0]   s1_bits;
  logic [S2_W-1:0]   s2_bits;
  logic              s1_valid, s2_ready;
  logic [2:0]        flags_d, flags_q;

  logic [LAMP_FLOAT_EXT_DW-1:0] f_n;
  logic [LAMP_FLOAT_E_DW:0]     e_n;
  logic                         inc;

  // Stage 1: pre-normalise a carry-out and round to 7 fraction bits.
  always_comb begin
    f_n = f_i;
    e_n = {1'b0, e_i};
    if (f_i[LAMP_EXT_CARRY_IDX]) begin
      f_n = {1'b0, f_i[LAMP_FLOAT_EXT_DW-1:1]};
      f_n[LAMP_EXT_S_IDX] = f_i[LAMP_EXT_R_IDX] | f_i[LAMP_EXT_S_IDX];
      e_n = e_n + 9'd1;
    end
    inc = FUNC_rne_increment(f_n[LAMP_EXT_F_LSB_IDX], f_n[LAMP_EXT_G_IDX],
                             f_n[LAMP_EXT_R_IDX], f_n[LAMP_EXT_S_IDX]);

    s1_d          = '0;
    s1_d.s        = s_i;
    s1_d.to_round = isToRound_i;
    s1_d.ovf      = isOverflow_i;
    s1_d.unf      = isUnderflow_i;
    if (isToRound_i) begin
      s1_d.e   = e_n;
      s1_d.sig = {f_n[LAMP_EXT_CARRY_IDX:LAMP_EXT_HIDDEN_IDX],
                  f_n[LAMP_EXT_F_MSB_IDX:LAMP_EXT_F_LSB_IDX]} + {8'd0, inc};
      s1_d.inx = |f_n[LAMP_EXT_G_IDX:LAMP_EXT_S_IDX];
    end else begin
      // Specials and zeros pass through untouched; bit 8 stays clear so no renormalise.
      s1_d.e   = {1'b0, e_i};
      s1_d.sig = {2'b01, f_i[LAMP_EXT_F_MSB_IDX:LAMP_EXT_F_LSB_IDX]};
      s1_d.inx = 1'b0;
    end
  end

  lamp_fpu_pipe_reg #(.DW(S1_W)) u_s1 (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (s1_d),
    .valid_o (s1_valid),
    .ready_i (s2_ready),
    .data_o  (s1_bits)
  );

  assign s1_q = rp_s1_t'(s1_bits);

  logic [LAMP_FLOAT_E_DW:0]   e_r;
  logic [LAMP_FLOAT_F_DW-1:0] frac_r;
  logic                       ovf_all;

  // Stage 2: renormalise a rounding carry, then saturate; overflow beats underflow.
  always_comb begin
    e_r     = s1_q.e + {8'd0, s1_q.sig[LAMP_FLOAT_F_DW+1]};
    frac_r  = s1_q.sig[LAMP_FLOAT_F_DW+1] ? '0 : s1_q.sig[LAMP_FLOAT_F_DW-1:0];
    ovf_all = s1_q.ovf | (s1_q.to_round & (e_r >= 9'd255));

    s2_d     = '0;
    s2_d.res = {s1_q.s, e_r[LAMP_FLOAT_E_DW-1:0], frac_r};
    s2_d.inx = s1_q.inx;
    if (ovf_all) begin
      s2_d.res = {s1_q.s, INF_E_F};
      s2_d.ovf = 1'b1;
      s2_d.inx = 1'b1;
    end else if (s1_q.unf) begin
      s2_d.res = {s1_q.s, ZERO_E_F};
      s2_d.unf = 1'b1;
      s2_d.inx = 1'b1;
    end
  end

  lamp_fpu_pipe_reg #(.DW(S2_W)) u_s2 (
    .clk     (clk),
    .rst     (rst),
    .valid_i (s1_valid),
    .ready_o (s2_ready),
    .data_i  (s2_d),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (s2_bits)
  );

  assign s2_q  = rp_s2_t'(s2_bits);
  assign res_o = s2_q.res;
  assign ovf_o = s2_q.ovf;
  assign unf_o = s2_q.unf;
  assign inx_o = s2_q.inx;

  // A clear and a same-cycle handshake: the new result's flags survive.
  always_comb begin
    flags_d = clear_flags_i ? 3'b000 : flags_q;
    if (valid_o & ready_i) flags_d = flags_d | {s2_q.ovf, s2_q.unf, s2_q.inx};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_q <= 3'b000;
    else     flags_q <= flags_d;
  end

  assign flags_o = flags_q;

endmodule
